pass_sequencer: RTL and testbench

PASS_SEQUENCER -- requirements
Module: pass_sequencer

---
 rtl/pass_pkg.sv | 22 ++
 rtl/en_edge.sv | 27 ++
 rtl/pass_sequencer.sv | 178 +++++++++++++++++
 tb/tb_pass_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pass_pkg.sv
// Shared definitions for the pass-code sequencer: FSM state encoding and default sizing.
package pass_pkg;

  typedef enum logic [2:0] {
    ST_ENTER   = 3'd0,
    ST_PROGRAM = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam int DEF_DIGITS      = 4;
  localparam int DEF_DW          = 4;
  localparam int DEF_MAX_TRIES   = 3;
  localparam int DEF_LOCK_CYCLES = 1000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/en_edge.sv
// Rising-edge detector for the debounced enter button; stays disarmed after reset
// until the button has been seen released, so a held button cannot fire on reset exit.
module en_edge (
  input  logic CLK,
  input  logic RST_N,
  input  logic EN,
  output logic RISE
);

  logic en_q;
  logic armed;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      en_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      en_q <= EN;
      if (!EN) begin
        armed <= 1'b1;
      end
    end
  end

  assign RISE = armed & EN & ~en_q;

endmodule

// File: rtl/pass_sequencer.sv
// Keypad pass-code sequencer: digit capture, code check, reprogramming and
// timed lockout after repeated failures. All outputs come from registered state.
module pass_sequencer
  import pass_pkg::*;
#(
  parameter int DIGITS      = DEF_DIGITS,
  parameter int DW          = DEF_DW,
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter logic [DIGITS*DW-1:0] INIT_CODE = '0
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         EN,
  input  logic                         MODE,
  input  logic [DW-1:0]                SW,
  output logic [$clog2(DIGITS+1)-1:0]  IDX,
  output logic [DIGITS-1:0]            LEDS,
  output logic                         UNLOCK,
  output logic                         FAIL,
  output logic                         LOCKED,
  output logic                         PROG
);

  localparam int IW = $clog2(DIGITS + 1);
  localparam int FW = cnt_width(MAX_TRIES + 1);
  localparam int LW = cnt_width(LOCK_CYCLES);
  localparam int CW = DIGITS * DW;

  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
  localparam logic [FW-1:0] TRIES_MAX = FW'(MAX_TRIES);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

  state_t         state;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  entry;
  logic [CW-1:0]  code;
  logic [CW-1:0]  entry_next;
  logic [FW-1:0]  fail_cnt;
  logic [FW-1:0]  fail_next;
  logic [LW-1:0]  lock_cnt;
  logic           unlock_r;
  logic           fail_r;
  logic           locked_r;
  logic           prog_r;
  logic           ev;

  en_edge u_en_edge (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (EN),
    .RISE  (ev)
  );

  // Entry buffer with the current switches dropped into slot idx; the program path
  // copies this straight into the stored code so the last digit is not lost.
  always_comb begin
    entry_next = entry;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        entry_next[i*DW +: DW] = SW;
      end
    end
  end

  always_comb begin
    fail_next = (fail_cnt == TRIES_MAX) ? fail_cnt : fail_cnt + 1'b1;
  end

  always_comb begin
    LEDS = '0;
    for (int i = 0; i < DIGITS; i++) begin
      LEDS[i] = (idx > IW'(i));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_ENTER;
      idx      <= '0;
      entry    <= '0;
      code     <= INIT_CODE;
      fail_cnt <= '0;
      lock_cnt <= '0;
      unlock_r <= 1'b0;
      fail_r   <= 1'b0;
      locked_r <= 1'b0;
      prog_r   <= 1'b0;
    end else begin
      fail_r <= 1'b0;
      case (state)
        ST_ENTER: begin
          if (ev) begin
            entry <= entry_next;
            idx   <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state <= ST_CHECK;
            end
          end
        end

        ST_PROGRAM: begin
          if (ev) begin
            entry <= entry_next;
            if (idx == LAST_IDX) begin
              code   <= entry_next;
              idx    <= '0;
              prog_r <= 1'b0;
              state  <= ST_ENTER;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        ST_CHECK: begin
          idx <= '0;
          if (entry == code) begin
            fail_cnt <= '0;
            unlock_r <= 1'b1;
            state    <= ST_OPEN;
          end else begin
            fail_r   <= 1'b1;
            fail_cnt <= fail_next;
            if (fail_next == TRIES_MAX) begin
              lock_cnt <= '0;
              locked_r <= 1'b1;
              state    <= ST_LOCKOUT;
            end else begin
              state <= ST_ENTER;
            end
          end
        end

        ST_OPEN: begin
          if (ev) begin
            unlock_r <= 1'b0;
            idx      <= '0;
            if (MODE) begin
              prog_r <= 1'b1;
              state  <= ST_PROGRAM;
            end else begin
              state <= ST_ENTER;
            end
          end
        end

        // Button presses are deliberately ignored until the timer expires.
        ST_LOCKOUT: begin
          if (lock_cnt == LOCK_LAST) begin
            lock_cnt <= '0;
            fail_cnt <= '0;
            locked_r <= 1'b0;
            state    <= ST_ENTER;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end

        default: begin
          state    <= ST_ENTER;
          idx      <= '0;
          lock_cnt <= '0;
          unlock_r <= 1'b0;
          locked_r <= 1'b0;
          prog_r   <= 1'b0;
        end
      endcase
    end
  end

  assign IDX    = idx;
  assign UNLOCK = unlock_r;
  assign FAIL   = fail_r;
  assign LOCKED = locked_r;
  assign PROG   = prog_r;

endmodule

// File: tb/tb_pass_sequencer.sv
// Randomised self-checking bench for pass_sequencer against a transaction-level
// model of the lock (stored code, failure tally, open/closed).
module tb_pass_sequencer;

  localparam int DIGITS      = 4;
  localparam int DW          = 4;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 20;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EN;
  logic        MODE;
  logic [3:0]  SW;
  logic [2:0]  IDX;
  logic [3:0]  LEDS;
  logic        UNLOCK;
  logic        FAIL;
  logic        LOCKED;
  logic        PROG;

  int tests  = 0;
  int errors = 0;

  logic [15:0] mCode;
  int          mFails;
  bit          mOpen;

  pass_sequencer #(
    .DIGITS      (DIGITS),
    .DW          (DW),
    .MAX_TRIES   (MAX_TRIES),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .EN     (EN),
    .MODE   (MODE),
    .SW     (SW),
    .IDX    (IDX),
    .LEDS   (LEDS),
    .UNLOCK (UNLOCK),
    .FAIL   (FAIL),
    .LOCKED (LOCKED),
    .PROG   (PROG)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run still active, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] thermo(input int n);
    return 4'((1 << n) - 1);
  endfunction

  // Raise EN with the given switches/mode and return one cycle later, EN still high.
  task automatic applyStimulus(input logic [3:0] sw, input logic mode);
    @(negedge CLK);
    SW   = sw;
    MODE = mode;
    EN   = 1'b1;
    @(negedge CLK);
  endtask

  task automatic releaseEn(input int extra);
    repeat (extra) @(negedge CLK);
    EN = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge CLK);
      SW = 4'($urandom);
    end
  endtask

  task automatic runLockout(input int seen);
    int cnt;
    int guard;
    cnt   = seen;
    guard = 0;
    while (LOCKED === 1'b1 && guard < 100) begin
      checkOutput("lock_idx", IDX, 0);
      EN = 1'($urandom_range(0, 1));
      SW = 4'($urandom);
      @(negedge CLK);
      guard++;
      if (LOCKED === 1'b1) cnt++;
    end
    EN = 1'b0;
    checkOutput("lock_len", cnt, LOCK_CYCLES);
    checkOutput("lock_exit_idx", IDX, 0);
    checkOutput("lock_exit_unlock", UNLOCK, 0);
    mFails = 0;
  endtask

  task automatic runEntry(input logic [15:0] code, input int firstHold, input bit stopInLockout);
    bit match;
    for (int k = 0; k < DIGITS; k++) begin
      applyStimulus(code[k*4 +: 4], 1'($urandom_range(0, 1)));
      checkOutput("entry_idx", IDX, k + 1);
      checkOutput("entry_leds", LEDS, thermo(k + 1));
      checkOutput("entry_unlock", UNLOCK, 0);
      if (k < DIGITS - 1) begin
        releaseEn((k == 0) ? firstHold : $urandom_range(0, 2));
        checkOutput("entry_idx_hold", IDX, k + 1);
      end
    end
    @(negedge CLK);
    match = (code == mCode);
    if (match) begin
      mFails = 0;
      mOpen  = 1'b1;
      checkOutput("verdict_unlock", UNLOCK, 1);
      checkOutput("verdict_fail", FAIL, 0);
      checkOutput("verdict_locked", LOCKED, 0);
    end else begin
      if (mFails < MAX_TRIES) mFails++;
      checkOutput("verdict_fail", FAIL, 1);
      checkOutput("verdict_unlock", UNLOCK, 0);
      checkOutput("verdict_locked", LOCKED, (mFails == MAX_TRIES));
    end
    checkOutput("verdict_idx", IDX, 0);
    EN = 1'b0;
    @(negedge CLK);
    checkOutput("fail_pulse_end", FAIL, 0);
    if (!match && mFails == MAX_TRIES && !stopInLockout) runLockout(2);
  endtask

  task automatic runOpenAction(input bit mode, input logic [15:0] newCode);
    applyStimulus(4'($urandom), mode);
    checkOutput("open_unlock_fall", UNLOCK, 0);
    checkOutput("open_idx", IDX, 0);
    checkOutput("open_prog", PROG, mode);
    releaseEn($urandom_range(0, 2));
    mOpen = 1'b0;
    checkOutput("open_idx_hold", IDX, 0);
    if (mode) begin
      for (int k = 0; k < DIGITS; k++) begin
        applyStimulus(newCode[k*4 +: 4], 1'($urandom_range(0, 1)));
        checkOutput("prog_idx", IDX, (k < DIGITS - 1) ? k + 1 : 0);
        checkOutput("prog_flag", PROG, (k < DIGITS - 1));
        checkOutput("prog_leds", LEDS, thermo((k < DIGITS - 1) ? k + 1 : 0));
        releaseEn($urandom_range(0, 2));
      end
      mCode = newCode;
    end
  endtask

  task automatic runReset(input bit holdEn);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("rst_async", {IDX, LEDS, UNLOCK, FAIL, LOCKED, PROG}, 0);
    EN = holdEn;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("rst_release_idx", IDX, 0);
    checkOutput("rst_release_unlock", UNLOCK, 0);
    EN     = 1'b0;
    mCode  = 16'h0000;
    mFails = 0;
    mOpen  = 1'b0;
  endtask

  initial begin
    RST_N  = 1'b1;
    EN     = 1'b0;
    MODE   = 1'b0;
    SW     = 4'h0;
    mCode  = 16'h0000;
    mFails = 0;
    mOpen  = 1'b0;
    #1;
    RST_N = 1'b0;
    #11;
    checkOutput("reset_outputs", {IDX, LEDS, UNLOCK, FAIL, LOCKED, PROG}, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Default code opens, then relock without capturing a digit.
    runEntry(16'h0000, 0, 1'b0);
    runOpenAction(1'b0, 16'h0000);
    runEntry(16'h0000, 1, 1'b0);

    // Reprogram to 3,7,1,9; old code must now fail, new one must open.
    runOpenAction(1'b1, 16'h9173);
    runEntry(16'h0000, 0, 1'b0);
    runEntry(16'h9173, 0, 1'b0);
    runOpenAction(1'b0, 16'h0000);

    // First digit held for 50 cycles counts once.
    runEntry(16'h0005, 49, 1'b0);

    // Clear the tally, then three wrong codes into a full lockout.
    runEntry(16'h9173, 0, 1'b0);
    runOpenAction(1'b0, 16'h0000);
    runEntry(16'h1111, 0, 1'b0);
    runEntry(16'h0000, 0, 1'b0);
    runEntry(16'hFFFF, 0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      if (mOpen) begin
        if ($urandom_range(0, 1) == 1) runOpenAction(1'b1, 16'($urandom));
        else runOpenAction(1'b0, 16'h0000);
      end else begin
        runEntry(($urandom_range(0, 1) == 1) ? mCode : 16'($urandom), $urandom_range(0, 3), 1'b0);
      end
    end
    if (mOpen) runOpenAction(1'b0, 16'h0000);

    // Reset after two digits restores the initial code.
    applyStimulus(4'h1, 1'b0);
    releaseEn(0);
    applyStimulus(4'h2, 1'b0);
    runReset(1'b0);
    runEntry(16'h0000, 0, 1'b0);
    runOpenAction(1'b0, 16'h0000);

    // Reset in the middle of a lockout, with EN held across release.
    runEntry(16'h1234, 0, 1'b1);
    runEntry(16'h1234, 0, 1'b1);
    runEntry(16'h1234, 0, 1'b1);
    checkOutput("lockout_before_reset", LOCKED, 1);
    runReset(1'b1);
    runEntry(16'h0000, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
